// File: rtl/wb_core_sram_bridge.sv
// wb_core_sram_bridge: registered Wishbone slave fanning one WB port out to NUM_BANKS core SRAM ports (req/rvalid).
// Optional macro CORE_SRAM_TIMEOUT_EN: give up on a silent bank after TIMEOUT WAIT cycles with an error pulse.
module wb_core_sram_bridge #(
    parameter int NUM_BANKS = 2,
    parameter int BANK_AW   = 10,
    parameter int TIMEOUT   = 15,
    localparam int BSEL_W   = $clog2(NUM_BANKS),
    localparam int AW       = BANK_AW + BSEL_W
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_we_i,
    input  logic [3:0]                   wbs_sel_i,
    input  logic [AW-1:0]                wbs_adr_i,
    input  logic [31:0]                  wbs_dat_i,
    output logic [31:0]                  wbs_dat_o,
    output logic                         wbs_ack_o,
    output logic                         wbs_err_o,
    output logic [NUM_BANKS-1:0]         core_data_req_o,
    output logic [NUM_BANKS-1:0]         core_data_we_o,
    output logic [NUM_BANKS*BANK_AW-1:0] core_data_addr_o,
    output logic [NUM_BANKS*4-1:0]       core_data_be_o,
    output logic [NUM_BANKS*32-1:0]      core_data_wdata_o,
    input  logic [NUM_BANKS*32-1:0]      core_data_rdata_i,
    input  logic [NUM_BANKS-1:0]         core_data_rvalid_i
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_ACK  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [BANK_AW-1:0]   addr_q, addr_d;
    logic [BSEL_W-1:0]    bank_q, bank_d;
    logic [3:0]           sel_q, sel_d;
    logic                 we_q, we_d;
    logic [31:0]          wdat_q, wdat_d;
    logic [31:0]          dat_q, dat_d;
    logic                 abort_q, abort_d;
    logic [NUM_BANKS-1:0] bank_hit;
    logic [BSEL_W-1:0]    adr_bank;
    logic                 busy;
    logic                 rvalid_sel;
    logic [31:0]          rdata_sel;
    logic                 timeout;

    assign adr_bank  = wbs_adr_i[AW-1:BANK_AW];
    assign busy      = (state_q == S_REQ) || (state_q == S_WAIT);
    assign wbs_dat_o = dat_q;
    assign wbs_ack_o = state_q == S_ACK;
    assign wbs_err_o = state_q == S_ERR;

    // Only the selected bank sees the captured transfer, and only while REQ/WAIT.
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        assign bank_hit[g]                          = busy && (bank_q == BSEL_W'(g));
        assign core_data_req_o[g]                   = bank_hit[g] && (state_q == S_REQ);
        assign core_data_we_o[g]                    = bank_hit[g] && we_q;
        assign core_data_addr_o[g*BANK_AW +: BANK_AW] = bank_hit[g] ? addr_q : '0;
        assign core_data_be_o[g*4 +: 4]             = bank_hit[g] ? sel_q : '0;
        assign core_data_wdata_o[g*32 +: 32]        = bank_hit[g] ? wdat_q : '0;
    end

    always_comb begin
        rvalid_sel = 1'b0;
        rdata_sel  = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            rvalid_sel = rvalid_sel | (bank_hit[i] & core_data_rvalid_i[i]);
            rdata_sel  = rdata_sel | (bank_hit[i] ? core_data_rdata_i[i*32 +: 32] : 32'd0);
        end
    end

`ifdef CORE_SRAM_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    logic [TW-1:0] cnt_q, cnt_d;
    assign cnt_d   = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
    assign timeout = (state_q == S_WAIT) && (cnt_q == TW'(TIMEOUT - 1));
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    localparam int timeout_unused = TIMEOUT;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bank_d  = bank_q;
        sel_d   = sel_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        dat_d   = dat_q;
        abort_d = abort_q;
        case (state_q)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    addr_d  = wbs_adr_i[BANK_AW-1:0];
                    bank_d  = adr_bank;
                    sel_d   = wbs_sel_i;
                    we_d    = wbs_we_i;
                    wdat_d  = wbs_dat_i;
                    abort_d = 1'b0;
                    state_d = (32'(adr_bank) < NUM_BANKS) ? S_REQ : S_ERR;
                    dat_d   = (32'(adr_bank) < NUM_BANKS) ? dat_q : 32'd0;
                end
            end
            S_REQ: begin
                abort_d = abort_q | ~wbs_cyc_i;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A dropped cycle cannot cancel the core access; it only silences the reply.
                abort_d = abort_q | ~wbs_cyc_i;
                if (rvalid_sel) begin
                    dat_d   = we_q ? dat_q : rdata_sel;
                    state_d = abort_d ? S_IDLE : S_ACK;
                end else if (timeout) begin
                    dat_d   = 32'd0;
                    state_d = abort_d ? S_IDLE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            bank_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            dat_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bank_q  <= bank_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            dat_q   <= dat_d;
            abort_q <= abort_d;
        end
    end
endmodule

// File: tb/tb_wb_core_sram_bridge.sv
// tb_wb_core_sram_bridge: scoreboard bench for wb_core_sram_bridge with three banks and an SRAM responder model.
module tb_wb_core_sram_bridge;
    localparam int NB  = 3;
    localparam int BAW = 10;
    localparam int AW  = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]        sel = '0;
    logic [AW-1:0]     adr = '0;
    logic [31:0]       dat_i = '0;
    logic [31:0]       dat_o;
    logic              ack, err;
    logic [NB-1:0]     req, we_o;
    logic [NB*BAW-1:0] addr_o;
    logic [NB*4-1:0]   be_o;
    logic [NB*32-1:0]  wdata_o;
    logic [NB*32-1:0]  rdata = '0;
    logic [NB-1:0]     rvalid = '0;

    wb_core_sram_bridge #(.NUM_BANKS(NB), .BANK_AW(BAW), .TIMEOUT(15)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o),
        .wbs_ack_o(ack), .wbs_err_o(err), .core_data_req_o(req), .core_data_we_o(we_o),
        .core_data_addr_o(addr_o), .core_data_be_o(be_o), .core_data_wdata_o(wdata_o),
        .core_data_rdata_i(rdata), .core_data_rvalid_i(rvalid)
    );

    always #5 clk = ~clk;

    typedef struct { int bank; logic [9:0] addr; bit w; logic [3:0] be; logic [31:0] wdata; int d; } req_t;
    typedef struct { bit e; logic [31:0] dat; } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] sram [int];
    logic [31:0] exp_dat = '0;
    int checks = 0, failures = 0;

    function automatic logic [31:0] init_val(input int key);
        return 32'hA5A5_0000 ^ (32'(key) * 32'h0001_9E37);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ack"}, 64'(ack), 0);
        check({tag, "_err"}, 64'(err), 0);
        check({tag, "_dat"}, 64'(dat_o), 0);
        check({tag, "_req"}, 64'(req), 0);
        check({tag, "_we"}, 64'(we_o), 0);
        check({tag, "_addr"}, 64'(addr_o), 0);
        check({tag, "_be"}, 64'(be_o), 0);
        check({tag, "_wdata"}, 64'(wdata_o), 0);
    endtask

    // WB monitor: every ack/err must match the oldest outstanding expectation.
    always @(negedge clk) begin
        rsp_t r;
        if (!rst && (ack || err)) begin
            if (rsp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_response: ack=%0b err=%0b with nothing outstanding", ack, err);
            end else begin
                r = rsp_q.pop_front();
                check("resp_kind", 64'({ack, err}), r.e ? 64'd1 : 64'd2);
                check("resp_dat", 64'(dat_o), 64'(r.dat));
            end
        end
    end

    // SRAM responder: checks the bank-side outputs every cycle and answers after the chosen delay.
    int   act = -1, cnt = 0, late = -1;
    bit   first = 0;
    req_t cur;
    always @(negedge clk) begin
        int key;
        logic [31:0] m;
        if (rst) begin
            if (act >= 0 && cur.d == 0) late = act;
            act = -1;
            rvalid = '0;
        end else begin
            first = 0;
            if (act < 0 && |req) begin
                if (req_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: req=%b", req);
                end else begin
                    cur = req_q.pop_front();
                    act = cur.bank;
                    cnt = cur.d;
                    first = 1;
                end
            end
            for (int k = 0; k < NB; k++) begin
                check($sformatf("req[%0d]", k), 64'(req[k]), 64'(k == act && first));
                check($sformatf("we[%0d]", k), 64'(we_o[k]), 64'(k == act && cur.w));
                check($sformatf("addr[%0d]", k), 64'(addr_o[k*BAW +: BAW]), k == act ? 64'(cur.addr) : 64'd0);
                check($sformatf("be[%0d]", k), 64'(be_o[k*4 +: 4]), k == act ? 64'(cur.be) : 64'd0);
                check($sformatf("wdata[%0d]", k), 64'(wdata_o[k*32 +: 32]), k == act ? 64'(cur.wdata) : 64'd0);
            end
            rvalid = '0;
            if (late >= 0) begin
                rdata[late*32 +: 32] = 32'h5A5A_5A5A;
                rvalid[late] = 1'b1;
                late = -1;
            end else if (act >= 0 && !first && cur.d > 0) begin
                cnt--;
                if (cnt == 0) begin
                    key = act * 1024 + int'(cur.addr);
                    m = sram.exists(key) ? sram[key] : init_val(key);
                    if (cur.w) begin
                        for (int i = 0; i < 4; i++) if (cur.be[i]) m[i*8 +: 8] = cur.wdata[i*8 +: 8];
                        sram[key] = m;
                        rdata[act*32 +: 32] = 32'hBAD0_0000 | 32'(cur.addr);
                    end else begin
                        rdata[act*32 +: 32] = m;
                    end
                    rvalid[act] = 1'b1;
                    act = -1;
                end else if (cnt == cur.d - 1) begin
                    rvalid[(act + NB - 1) % NB] = 1'b1;
                    rdata[((act + NB - 1) % NB)*32 +: 32] = 32'hDEAD_0000 | 32'(cnt);
                end
            end
        end
    end

    // mode 0: normal transfer; 1: cyc dropped in WAIT; 2: reset while WAIT with a late rvalid.
    task automatic txn(input bit w, input int b, input logic [9:0] a, input logic [3:0] s,
                       input logic [31:0] d32, input int d, input int mode);
        int key;
        int n;
        bit e;
        logic [31:0] m;
        e = b >= NB;
        key = b * 1024 + int'(a);
        cyc = 1'b1; stb = 1'b1; we = w; adr = {2'(b), a}; sel = s; dat_i = d32;
        if (e) begin
            exp_dat = '0;
        end else begin
            req_q.push_back('{b, a, w, s, d32, d});
            m = ref_mem.exists(key) ? ref_mem[key] : init_val(key);
            if (w) begin
                for (int i = 0; i < 4; i++) if (s[i]) m[i*8 +: 8] = d32[i*8 +: 8];
                ref_mem[key] = m;
            end else begin
                exp_dat = m;
            end
        end
        if (mode == 0) begin
            rsp_q.push_back('{e, exp_dat});
            n = -1;
            do begin
                @(negedge clk);
                n++;
            end while (!(ack || err) && n < 60);
            check("latency", 64'(n), e ? 64'd1 : 64'(2 + d));
            @(posedge clk); #1;
            if ($urandom_range(1) == 1) begin
                cyc = 1'b0; stb = 1'b0;
                repeat ($urandom_range(2)) begin @(posedge clk); #1; end
            end
        end else if (mode == 1) begin
            repeat (2) begin @(posedge clk); #1; end
            cyc = 1'b0; stb = 1'b0;
            repeat (d + 4) begin @(posedge clk); #1; end
        end else begin
            repeat (3) begin @(posedge clk); #1; end
            rst = 1'b1; cyc = 1'b0; stb = 1'b0; exp_dat = '0;
            #1;
            check_quiet("midreset");
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (5) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        int b, m, d;
        bit w;
        logic [9:0] a;
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        txn(0, 0, 10'h005, 4'hF, 32'h0, 1, 0);
        txn(1, 1, 10'h3FF, 4'b0110, 32'h1234_5678, 1, 0);
        txn(0, 1, 10'h3FF, 4'hF, 32'h0, 2, 0);
        txn(0, 3, 10'h001, 4'hF, 32'h0, 1, 0);
        txn(0, 1, 10'h3FF, 4'hF, 32'h0, 5, 0);
        txn(1, 2, 10'h010, 4'hF, 32'hCAFE_F00D, 3, 1);
        txn(0, 2, 10'h010, 4'hF, 32'h0, 1, 0);
        txn(0, 1, 10'h004, 4'hF, 32'h0, 0, 2);
        txn(0, 0, 10'h005, 4'hF, 32'h0, 1, 0);
        for (int i = 0; i < 300; i++) begin
            w = 1'($urandom_range(1));
            b = ($urandom_range(7) == 0) ? 3 : int'($urandom_range(NB - 1));
            a = ($urandom_range(9) == 0) ? 10'h3FF : 10'($urandom_range(7));
            d = int'($urandom_range(1, 4));
            m = ($urandom_range(19) == 0 && b < NB) ? int'($urandom_range(1, 2)) : 0;
            if (m == 1) w = 1'b1;
            if (m == 2) begin w = 1'b0; d = 0; end
            txn(w, b, a, 4'($urandom_range(15)), $urandom, d, m);
        end
        cyc = 1'b0; stb = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        check("rsp_q_empty", 64'(rsp_q.size()), 0);
        check("req_q_empty", 64'(req_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
